// File: rtl/manhattan_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : manhattan_bit_serializer
// Brief    : Parallel-to-serial shifter with a one-word skid buffer that feeds
//            a downstream sequence detector one registered bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
module manhattan_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int            CNT_W       = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(WIDTH - 2);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shift_reg;
    logic [WIDTH-1:0]   hold_reg;
    logic               hold_full;
    logic [CNT_W-1:0]   bit_cnt;

    logic               accept;
    logic               last_bit;
    logic [WIDTH-1:0]   load_word;
    logic               head_bit;
    logic [WIDTH-1:0]   shift_next;
    logic               load_first_bit;
    logic [WIDTH-1:0]   load_rest;

    assign load_ready = !hold_full;
    assign accept     = load_valid && load_ready;
    assign last_bit   = (state == SHIFT) && (bit_cnt == LAST_IDX);
    assign busy       = (state == SHIFT) || hold_full;

    // A held word always takes priority; when hold is full load_ready is low,
    // so data_in can never be accepted on the same edge.
    assign load_word  = hold_full ? hold_reg : data_in;

    // shift_reg keeps the not-yet-emitted bits with the next one at its head;
    // the bit currently on the line lives only in the serial_out register.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign head_bit       = shift_reg[WIDTH-1];
            assign shift_next     = {shift_reg[WIDTH-2:0], 1'b0};
            assign load_first_bit = load_word[WIDTH-1];
            assign load_rest      = {load_word[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign head_bit       = shift_reg[0];
            assign shift_next     = {1'b0, shift_reg[WIDTH-1:1]};
            assign load_first_bit = load_word[0];
            assign load_rest      = {1'b0, load_word[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            hold_reg     <= '0;
            hold_full    <= 1'b0;
            bit_cnt      <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            word_done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg    <= load_rest;
                        serial_out   <= load_first_bit;
                        serial_valid <= 1'b1;
                        word_done    <= 1'b0;
                        bit_cnt      <= '0;
                        state        <= SHIFT;
                    end else begin
                        serial_out   <= 1'b0;
                        serial_valid <= 1'b0;
                        word_done    <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (last_bit) begin
                        if (hold_full || accept) begin
                            // Next word follows with no gap cycle.
                            shift_reg    <= load_rest;
                            serial_out   <= load_first_bit;
                            serial_valid <= 1'b1;
                            word_done    <= 1'b0;
                            bit_cnt      <= '0;
                            hold_full    <= 1'b0;
                        end else begin
                            shift_reg    <= '0;
                            serial_out   <= 1'b0;
                            serial_valid <= 1'b0;
                            word_done    <= 1'b0;
                            bit_cnt      <= '0;
                            state        <= IDLE;
                        end
                    end else begin
                        shift_reg    <= shift_next;
                        serial_out   <= head_bit;
                        serial_valid <= 1'b1;
                        word_done    <= (bit_cnt == PENULT_IDX);
                        bit_cnt      <= bit_cnt + CNT_W'(1);
                        if (accept) begin
                            hold_reg  <= data_in;
                            hold_full <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_manhattan_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_manhattan_bit_serializer
// Brief    : Bench for the bit serializer: MSB-first and LSB-first instances
//            compared each cycle against a bit-queue model of the output line.
// Revision : 1.0 - initial release
// ============================================================================
module tb_manhattan_bit_serializer;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] d0 = '0;
    logic [W-1:0] d1 = '0;
    logic         lv0 = 1'b0;
    logic         lv1 = 1'b0;

    logic ready0, so0, sv0, wd0, busy0;
    logic ready1, so1, sv1, wd1, busy1;

    always #5 clock = ~clock;

    manhattan_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset(reset), .data_in(d0), .load_valid(lv0),
        .load_ready(ready0), .serial_out(so0), .serial_valid(sv0),
        .word_done(wd0), .busy(busy0)
    );

    manhattan_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset(reset), .data_in(d1), .load_valid(lv1),
        .load_ready(ready1), .serial_out(so1), .serial_valid(sv1),
        .word_done(wd1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the line is a queue of {last_of_word, bit}; the front entry is
    // what is on serial_out now. More than one word queued means hold is full.
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    bit check_en = 1'b0;

    always @(posedge clock) begin : model
        bit a0, a1;
        if (!reset) begin
            q0.delete();
            q1.delete();
        end else begin
            a0 = lv0 && (q0.size() <= W);
            a1 = lv1 && (q1.size() <= W);
            if (q0.size() > 0) q0.delete(0);
            if (q1.size() > 0) q1.delete(0);
            if (a0) for (int i = 0; i < W; i++) q0.push_back({(i == W-1), d0[W-1-i]});
            if (a1) for (int i = 0; i < W; i++) q1.push_back({(i == W-1), d1[i]});
        end
        check_en = 1'b1;
    end

    always @(negedge clock) begin : compare
        if (check_en) begin
            cmp("msb serial_valid", 32'(sv0),    32'(q0.size() > 0));
            cmp("msb serial_out",   32'(so0),    32'((q0.size() > 0) ? q0[0][0] : 1'b0));
            cmp("msb word_done",    32'(wd0),    32'((q0.size() > 0) ? q0[0][1] : 1'b0));
            cmp("msb busy",         32'(busy0),  32'(q0.size() > 0));
            cmp("msb load_ready",   32'(ready0), 32'(q0.size() <= W));
            cmp("lsb serial_valid", 32'(sv1),    32'(q1.size() > 0));
            cmp("lsb serial_out",   32'(so1),    32'((q1.size() > 0) ? q1[0][0] : 1'b0));
            cmp("lsb word_done",    32'(wd1),    32'((q1.size() > 0) ? q1[0][1] : 1'b0));
            cmp("lsb busy",         32'(busy1),  32'(q1.size() > 0));
            cmp("lsb load_ready",   32'(ready1), 32'(q1.size() <= W));
        end
    end

    // Record of every emitted bit with its cycle stamp, plus word_done pulses.
    int   cyc = 0;
    logic s0[$];
    logic s1[$];
    int   t0[$];
    int   t1[$];
    int   dn0 = 0;
    int   dn1 = 0;

    always @(negedge clock) begin : collector
        cyc++;
        if (sv0 === 1'b1) begin s0.push_back(so0); t0.push_back(cyc); end
        if (sv1 === 1'b1) begin s1.push_back(so1); t1.push_back(cyc); end
        if (wd0 === 1'b1) dn0++;
        if (wd1 === 1'b1) dn1++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_stream(input int inst, input int mark, input int dmark, input int n,
                                input logic [31:0] exp, input int ndone, input string name);
        int got;
        logic [31:0] v;
        bit contig;
        got    = ((inst == 0) ? s0.size() : s1.size()) - mark;
        v      = '0;
        contig = 1'b1;
        cmp({name, " bit count"}, 32'(got), 32'(n));
        if (got == n) begin
            for (int i = 0; i < n; i++) begin
                v = {v[30:0], (inst == 0) ? s0[mark+i] : s1[mark+i]};
                if (i > 0) begin
                    if (inst == 0 && t0[mark+i] != t0[mark+i-1] + 1) contig = 1'b0;
                    if (inst == 1 && t1[mark+i] != t1[mark+i-1] + 1) contig = 1'b0;
                end
            end
            cmp({name, " bits"}, v, exp);
            cmp({name, " contiguous"}, 32'(contig), 32'd1);
        end
        cmp({name, " word_done count"}, 32'(((inst == 0) ? dn0 : dn1) - dmark), 32'(ndone));
    endtask

    initial begin : stimulus
        int m, dm;

        // Reset held for two edges with a word offered.
        reset = 1'b0; lv0 = 1'b1; lv1 = 1'b1; d0 = 8'hA5; d1 = 8'h5A;
        tick(2);
        cmp("reset serial_valid", 32'(sv0), 32'd0);
        cmp("reset serial_out",   32'(so0), 32'd0);
        cmp("reset busy",         32'(busy0), 32'd0);
        cmp("reset load_ready",   32'(ready0), 32'd1);
        reset = 1'b1; lv0 = 1'b0; lv1 = 1'b0;
        tick(3);
        cmp("reset no capture msb", 32'(s0.size()), 32'd0);
        cmp("reset no capture lsb", 32'(s1.size()), 32'd0);

        // Single word.
        m = s0.size(); dm = dn0;
        d0 = 8'hB4; lv0 = 1'b1;
        tick(1);
        lv0 = 1'b0; d0 = 8'h3C;
        cmp("model depth after accept", 32'(q0.size()), 32'd8);
        cmp("model first entry",        32'(q0[0]),     32'h1);
        tick(12);
        check_stream(0, m, dm, 8, 32'hB4, 1, "single");

        // Back-to-back with the second word held.
        m = s0.size(); dm = dn0;
        d0 = 8'hD0; lv0 = 1'b1;
        tick(1);
        lv0 = 1'b0;
        tick(1);
        d0 = 8'hFF; lv0 = 1'b1;
        tick(1);
        cmp("held load_ready", 32'(ready0), 32'd0);
        lv0 = 1'b0; d0 = 8'h00;
        tick(20);
        check_stream(0, m, dm, 16, 32'hD0FF, 2, "back2back");

        // Bypass on the last-bit cycle.
        m = s0.size(); dm = dn0;
        d0 = 8'hF0; lv0 = 1'b1;
        tick(1);
        lv0 = 1'b0;
        tick(7);
        d0 = 8'h0F; lv0 = 1'b1;
        tick(1);
        lv0 = 1'b0;
        tick(20);
        check_stream(0, m, dm, 16, 32'hF00F, 2, "bypass");

        // LSB-first instance.
        m = s1.size(); dm = dn1;
        d1 = 8'h01; lv1 = 1'b1;
        tick(1);
        lv1 = 1'b0;
        tick(12);
        check_stream(1, m, dm, 8, 32'h80, 1, "lsb first");

        // Reset after the 4th bit with a second word held.
        m = s0.size(); dm = dn0;
        d0 = 8'hAA; lv0 = 1'b1;
        tick(1);
        d0 = 8'h55;
        tick(1);
        lv0 = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(1);
        cmp("midreset serial_valid", 32'(sv0), 32'd0);
        cmp("midreset serial_out",   32'(so0), 32'd0);
        cmp("midreset busy",         32'(busy0), 32'd0);
        reset = 1'b1;
        tick(20);
        check_stream(0, m, dm, 4, 32'hA, 0, "midreset");

        // Random traffic with occasional resets.
        repeat (1500) begin
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            lv0   = 1'($urandom_range(0, 1));
            lv1   = 1'($urandom_range(0, 1));
            d0    = W'($urandom);
            d1    = W'($urandom);
            tick(1);
        end
        reset = 1'b1; lv0 = 1'b0; lv1 = 1'b0;
        tick(24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/manhattan_bit_serializer.md
MANHATTAN_BIT_SERIALIZER -- requirements
Module: manhattan_bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bits per parallel word, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 goes out first, 0 = bit 0 goes out first.
REQ-003 SHALL have port clock  input  1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-low reset (0 = reset, sampled on rising clock).
REQ-005 SHALL have port data_in  input  WIDTH: parallel word to serialize.
REQ-006 SHALL have port load_valid  input  1: data_in is valid this cycle.
REQ-007 SHALL have port load_ready  output  1: block can accept a word this cycle.
REQ-008 SHALL have port serial_out  output  1: registered serial bit, one per clock; drives the sequence detector's sequence_in.
REQ-009 SHALL have port serial_valid  output  1: serial_out carries a payload bit this cycle.
REQ-010 SHALL have port word_done  output  1: one-cycle pulse, high while the last bit of a word is on serial_out.
REQ-011 SHALL have port busy  output  1: high whenever a word is shifting or held.

Function
REQ-012 SHALL hold a shift register (WIDTH), a bit counter (ceil(log2 WIDTH) bits), and a one-word holding register with a full flag.
REQ-013 SHALL use two states: IDLE (nothing shifting) and SHIFT (word in shift register).
REQ-014 SHALL drive load_ready = NOT hold_full, combinationally; a word is accepted on an edge where load_valid AND load_ready.
REQ-015 IDLE + accept: word loads directly into the shift register, counter = 0, state -> SHIFT; first bit appears on serial_out in the cycle after the accepting edge (latency 1).
REQ-016 SHIFT: serial_out advances one bit per clock; counter increments; no stall, because the downstream detector has no backpressure.
REQ-017 SHIFT + accept, not the last-bit cycle: word goes into the holding register; hold_full = 1.
REQ-018 Last-bit cycle (counter = WIDTH-1), hold_full = 1: the held word moves into the shift register on that edge; hold_full clears; no gap cycle.
REQ-019 Last-bit cycle, hold empty, accept on the same edge: the word bypasses hold straight into the shift register; no gap cycle.
REQ-020 Last-bit cycle, hold empty, no accept: state -> IDLE; serial_valid = 0 from the next cycle.
REQ-021 Last-bit cycle, hold_full = 1, load_valid = 1: load_ready = 0, so nothing is accepted; the new word is taken earliest the next cycle.
REQ-022 When serial_valid = 0, serial_out SHALL be 0, so the idle line reads as zeros to the detector.
REQ-023 serial_valid SHALL be 1 exactly during payload-bit cycles; word_done SHALL assert once per word.
REQ-024 busy = (state = SHIFT) OR hold_full.
REQ-025 data_in SHALL be captured only on an accepting edge; later changes have no effect.

Reset
REQ-026 With reset = 0 at a rising edge: state = IDLE, counter = 0, hold_full = 0, shift/hold registers = 0.
REQ-027 Outputs after that edge: serial_out = 0, serial_valid = 0, word_done = 0, busy = 0, load_ready = 1.
REQ-028 Reset mid-word SHALL discard both the in-flight and the held word; no partial bits are emitted after the reset edge.
REQ-029 load_valid SHALL be ignored during reset cycles.

Verification (WIDTH=8 unless noted)
REQ-030 Reset: reset = 0 for 2 clocks with load_valid = 1 -> serial_valid = 0, serial_out = 0, busy = 0, load_ready = 1, no word captured.
REQ-031 Single word: accept 8'hB4 -> serial_out = 1,0,1,1,0,1,0,0 on 8 consecutive cycles starting 1 cycle after accept; word_done on the 8th; serial_valid = 0 after.
REQ-032 Back-to-back: accept 8'hD0, then 8'hFF two cycles later -> 16 contiguous valid bits (11010000 11111111); load_ready = 0 while the second word is held; 2 word_done pulses 8 cycles apart.
REQ-033 Bypass: with hold empty, accept 8'h0F on the last-bit cycle of 8'hF0 -> bits 11110000 00001111 with no gap.
REQ-034 LSB-first: MSB_FIRST = 0, accept 8'h01 -> serial_out = 1 then 0 x7.
REQ-035 Mid-word reset: accept 8'hAA, then 8'h55 (held); assert reset after 4th bit -> serial_valid = 0 and serial_out = 0 from the next cycle; busy = 0; 8'h55 never emitted.
